mpw_project_mux: RTL and testbench
==================================

Name: mpw_project_mux

Overview:
- Parametrised multi-project output multiplexer inside the user project wrapper.
- Selects one of NUM_PROJECTS user designs to drive the shared GPIO, LA and IRQ outputs.
- Project choice is set through a Wishbone register.
- Every switch runs a guarded isolate-then-reset sequence, so two projects never drive pads and a newly selected design always starts from reset.

Parameters:
- NUM_PROJECTS, 8, number of attached projects (2..16)
- IO_W, 38, GPIO width per project
- LA_W, 32, LA output width per project
- BASE_ADDR, 32'h3000_0000, Wishbone base; register block occupies 16 bytes
- DEFAULT_PROJECT, 0, project selected after reset
- GUARD_CYCLES, 4, isolation cycles before reset (>=1)
- RESET_CYCLES, 8, cycles new project is held in reset (>=1)

Ports:
- wb_clk_i  in  1  sole clock
- wb_rst_i  in  1  reset, synchronous, active-high
- wbs_stb_i  in  1  WB strobe
- wbs_cyc_i  in  1  WB cycle
- wbs_we_i  in  1  WB write enable
- wbs_sel_i  in  4  WB byte select
- wbs_adr_i  in  32  WB address
- wbs_dat_i  in  32  WB write data
- wbs_ack_o  out  1  WB acknowledge
- wbs_dat_o  out  32  WB read data
- proj_io_out  in  NUM_PROJECTS*IO_W  per-project io_out; project k occupies slice [k*IO_W +: IO_W]
- proj_io_oeb  in  NUM_PROJECTS*IO_W  per-project io_oeb
- proj_la_out  in  NUM_PROJECTS*LA_W  per-project LA outputs
- proj_irq  in  NUM_PROJECTS*3  per-project IRQs
- proj_rst  out  NUM_PROJECTS  per-project active-high reset
- io_out  out  IO_W  muxed GPIO out
- io_oeb  out  IO_W  muxed GPIO oeb (1 = input/high-Z)
- la_data_out  out  LA_W  muxed LA out
- user_irq  out  3  muxed IRQ

Behaviour:
- Clock and reset:
  - One clock: wb_clk_i. Reset wb_rst_i is synchronous and active-high.
  - Reset values: io_out=0, io_oeb=all 1, la_data_out=0, user_irq=0, proj_rst=all 1, wbs_ack_o=0, wbs_dat_o=0.
  - Reset values (internal): active_id=DEFAULT_PROJECT, enable=1, err=0, pending=0.
  - First cycle after reset: state=ISOLATE, target=DEFAULT_PROJECT.
- Registers (word offset from BASE_ADDR; hit = adr[31:4]==BASE_ADDR[31:4]):
  - 0x0 SEL: W bits[3:0] = requested project; R = active_id.
  - 0x4 CTRL: bit0 enable.
  - 0x8 STATUS (RO): bit0 busy (state!=ACTIVE), bit1 err, bits[15:8] NUM_PROJECTS.
  - 0xC: reads 0, writes ignored.
  - Writes take effect only when wbs_sel_i[0]=1.
- Wishbone handshake:
  - wbs_ack_o pulses 1 cycle, registered, the cycle after stb&cyc&hit while ack=0. Strobe held for N cycles gives an ack every other cycle.
  - wbs_dat_o is valid with ack and is 0 otherwise.
  - No ack is generated for a non-hit address.
- SEL write semantics:
  - Value >= NUM_PROJECTS: ignored, err<=1. err clears on the next valid SEL write.
  - Valid value: target<=value, pending<=1, even if equal to active_id (forces a re-reset).
- FSM:
  - ACTIVE: when pending, go to ISOLATE and clear pending.
  - ISOLATE: GUARD_CYCLES cycles, then go to RESET and set active_id<=target.
  - RESET: RESET_CYCLES cycles, then go to ACTIVE.
  - SEL write during ISOLATE/RESET: sets pending and updates target (last write wins). The current sequence completes first, then ACTIVE immediately re-enters ISOLATE on the next cycle.
- Outputs, registered with 1-cycle latency from proj_* inputs:
  - In ACTIVE with enable=1: io_out/io_oeb/la_data_out/user_irq = slice of active_id.
  - Otherwise: isolated values (io_out 0, io_oeb all 1, LA 0, IRQ 0).
  - enable=0: outputs isolated and proj_rst all 1; FSM state and active_id retained. Re-enabling does not re-run the sequence; use a SEL write for that.
- proj_rst:
  - Bit k=0 only when k==active_id, state==ACTIVE and enable=1; otherwise 1.
  - Registered and aligned with the output mux.
  - Isolated outputs must be visible on or before the cycle proj_rst rises.
- Reset mid-sequence: aborts to the reset values; any pending request is discarded.

Test Plan:
1. Reset with defaults -> 1 cycle after reset release, proj_rst=8'hFF and io_oeb all 1. After 4+8 cycles, proj_rst=8'hFE, io_out = project 0 slice one cycle later, STATUS reads 32'h0000_0800.
2. Write SEL=5 while projects drive distinct patterns (project k io_out=k) -> ack exactly 1 cycle after strobe. Outputs isolated for 12 cycles, proj_rst[5] low afterwards, io_out=5. SEL reads 5.
3. Write SEL=9 with NUM_PROJECTS=8 -> active_id unchanged, STATUS bit1=1. Then write SEL=2 -> err=0, switch to project 2.
4. Write SEL=3 during ISOLATE, then SEL=6 during RESET -> first sequence completes to the original target, immediately re-sequences, and finally active_id=6 (project 3 never activated).
5. Write CTRL=0 while in ACTIVE -> next cycle outputs isolated and proj_rst=all 1. Write CTRL=1 -> previous project released without a new guard period.
6. Assert wb_rst_i during RESET state of a switch to 4 -> all outputs at reset values, sequence restarts toward DEFAULT_PROJECT 0. Read of offset 0xC returns 0; an access at BASE_ADDR+0x10 gets no ack.

Source files
------------

// File: rtl/mpw_project_mux.sv
// mpw_project_mux
//   Multi-project output multiplexer for the user project wrapper. One of
//   NUM_PROJECTS attached designs drives the shared GPIO, LA and IRQ outputs.
//   The choice is made through a small Wishbone register block. Each switch
//   runs isolate-then-reset: pads go to safe values for GUARD_CYCLES, the new
//   project is held in reset for RESET_CYCLES, and only then is it connected.
//
// Ports
//   wb_clk_i, wb_rst_i   sole clock, synchronous active-high reset
//   wbs_*                Wishbone slave (SEL, CTRL, STATUS registers)
//   proj_io_out/io_oeb   per-project GPIO, project k at [k*IO_W +: IO_W]
//   proj_la_out          per-project LA outputs, [k*LA_W +: LA_W]
//   proj_irq             per-project IRQs, [k*3 +: 3]
//   proj_rst             per-project active-high reset
//   io_out, io_oeb       muxed GPIO (io_oeb 1 = input/high-Z)
//   la_data_out          muxed LA output
//   user_irq             muxed IRQ
module mpw_project_mux #(
  parameter int          NUM_PROJECTS    = 8,
  parameter int          IO_W            = 38,
  parameter int          LA_W            = 32,
  parameter logic [31:0] BASE_ADDR       = 32'h3000_0000,
  parameter int          DEFAULT_PROJECT = 0,
  parameter int          GUARD_CYCLES    = 4,
  parameter int          RESET_CYCLES    = 8
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_i,
  input  logic                         wbs_stb_i,
  input  logic                         wbs_cyc_i,
  input  logic                         wbs_we_i,
  input  logic [3:0]                   wbs_sel_i,
  input  logic [31:0]                  wbs_adr_i,
  input  logic [31:0]                  wbs_dat_i,
  output logic                         wbs_ack_o,
  output logic [31:0]                  wbs_dat_o,
  input  logic [NUM_PROJECTS*IO_W-1:0] proj_io_out,
  input  logic [NUM_PROJECTS*IO_W-1:0] proj_io_oeb,
  input  logic [NUM_PROJECTS*LA_W-1:0] proj_la_out,
  input  logic [NUM_PROJECTS*3-1:0]    proj_irq,
  output logic [NUM_PROJECTS-1:0]      proj_rst,
  output logic [IO_W-1:0]              io_out,
  output logic [IO_W-1:0]              io_oeb,
  output logic [LA_W-1:0]              la_data_out,
  output logic [2:0]                   user_irq
);

  typedef enum logic [1:0] {
    ST_ACTIVE  = 2'd0,
    ST_ISOLATE = 2'd1,
    ST_RESET   = 2'd2
  } state_t;

  localparam logic [3:0] DEF_ID = 4'(DEFAULT_PROJECT);

  state_t      state, state_next;
  logic [15:0] cnt, cnt_next;
  logic [3:0]  active_id;
  logic [3:0]  target;      // most recent valid SEL request
  logic [3:0]  seq_target;  // project the running sequence switches to
  logic        enable;
  logic        err;
  logic        pending;
  logic        load_seq;
  logic        commit;

  // Wishbone decode
  logic        hit;
  logic        access;
  logic        wr;
  logic [1:0]  off;
  logic        sel_wr;
  logic        sel_ok;
  logic        sel_valid;
  logic        busy;
  logic [31:0] rd_data;

  logic unused_wb;
  assign unused_wb = &{1'b0, wbs_sel_i[3:1], wbs_adr_i[1:0], wbs_dat_i[31:4]};

  assign hit       = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign access    = wbs_stb_i && wbs_cyc_i && hit && !wbs_ack_o;
  assign wr        = access && wbs_we_i && wbs_sel_i[0];
  assign off       = wbs_adr_i[3:2];
  assign sel_wr    = wr && (off == 2'd0);
  assign sel_ok    = ({1'b0, wbs_dat_i[3:0]} < 5'(NUM_PROJECTS));
  assign sel_valid = sel_wr && sel_ok;
  assign busy      = (state != ST_ACTIVE);

  always_comb begin
    rd_data = '0;
    case (off)
      2'd0:    rd_data = {28'd0, active_id};
      2'd1:    rd_data = {31'd0, enable};
      2'd2:    rd_data = {16'd0, 8'(NUM_PROJECTS), 6'd0, err, busy};
      default: rd_data = '0;
    endcase
  end

  // Switch sequencer
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    load_seq   = 1'b0;
    commit     = 1'b0;
    case (state)
      ST_ACTIVE: begin
        if (pending) begin
          state_next = ST_ISOLATE;
          cnt_next   = '0;
          load_seq   = 1'b1;
        end
      end
      ST_ISOLATE: begin
        if (cnt == 16'(GUARD_CYCLES - 1)) begin
          state_next = ST_RESET;
          cnt_next   = '0;
          commit     = 1'b1;
        end else begin
          cnt_next = cnt + 16'd1;
        end
      end
      ST_RESET: begin
        if (cnt == 16'(RESET_CYCLES - 1)) begin
          state_next = ST_ACTIVE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 16'd1;
        end
      end
      default: begin
        state_next = ST_ISOLATE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= ST_ISOLATE;
      cnt        <= '0;
      active_id  <= DEF_ID;
      target     <= DEF_ID;
      seq_target <= DEF_ID;
      enable     <= 1'b1;
      err        <= 1'b0;
      pending    <= 1'b0;
      wbs_ack_o  <= 1'b0;
      wbs_dat_o  <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (load_seq) seq_target <= target;
      if (commit)   active_id  <= seq_target;
      // A new request in the same cycle the sequencer consumes the old one
      // must survive, so the write takes priority over the clear.
      if (sel_valid)     pending <= 1'b1;
      else if (load_seq) pending <= 1'b0;
      if (sel_valid) target <= wbs_dat_i[3:0];
      if (sel_wr)    err    <= !sel_ok;
      if (wr && (off == 2'd1)) enable <= wbs_dat_i[0];
      wbs_ack_o <= access;
      wbs_dat_o <= (access && !wbs_we_i) ? rd_data : 32'd0;
    end
  end

  // Output mux select
  logic                    live;
  logic [IO_W-1:0]         io_sel;
  logic [IO_W-1:0]         oeb_sel;
  logic [LA_W-1:0]         la_sel;
  logic [2:0]              irq_sel;
  logic [NUM_PROJECTS-1:0] rst_sel;

  assign live = (state == ST_ACTIVE) && enable;

  always_comb begin
    io_sel  = '0;
    oeb_sel = '1;
    la_sel  = '0;
    irq_sel = '0;
    rst_sel = '1;
    for (int k = 0; k < NUM_PROJECTS; k++) begin
      if (live && (active_id == 4'(k))) begin
        io_sel     = proj_io_out[k*IO_W +: IO_W];
        oeb_sel    = proj_io_oeb[k*IO_W +: IO_W];
        la_sel     = proj_la_out[k*LA_W +: LA_W];
        irq_sel    = proj_irq[k*3 +: 3];
        rst_sel[k] = 1'b0;
      end
    end
  end

  // Output register stage: pads and proj_rst change on the same edge, so
  // isolation is never later than the rising reset of the old project.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      io_out      <= '0;
      io_oeb      <= '1;
      la_data_out <= '0;
      user_irq    <= '0;
      proj_rst    <= '1;
    end else begin
      io_out      <= io_sel;
      io_oeb      <= oeb_sel;
      la_data_out <= la_sel;
      user_irq    <= irq_sel;
      proj_rst    <= rst_sel;
    end
  end

endmodule

// File: tb/tb_mpw_project_mux.sv
module tb_mpw_project_mux;

  localparam int          NP   = 8;
  localparam int          IO_W = 38;
  localparam int          LA_W = 32;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic              wb_clk_i = 1'b0;
  logic              wb_rst_i = 1'b1;
  logic              wbs_stb_i = 1'b0;
  logic              wbs_cyc_i = 1'b0;
  logic              wbs_we_i = 1'b0;
  logic [3:0]        wbs_sel_i = 4'h0;
  logic [31:0]       wbs_adr_i = 32'h0;
  logic [31:0]       wbs_dat_i = 32'h0;
  logic              wbs_ack_o;
  logic [31:0]       wbs_dat_o;
  logic [NP*IO_W-1:0] proj_io_out;
  logic [NP*IO_W-1:0] proj_io_oeb;
  logic [NP*LA_W-1:0] proj_la_out;
  logic [NP*3-1:0]    proj_irq;
  logic [NP-1:0]      proj_rst;
  logic [IO_W-1:0]    io_out;
  logic [IO_W-1:0]    io_oeb;
  logic [LA_W-1:0]    la_data_out;
  logic [2:0]         user_irq;

  mpw_project_mux dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .wbs_stb_i   (wbs_stb_i),
    .wbs_cyc_i   (wbs_cyc_i),
    .wbs_we_i    (wbs_we_i),
    .wbs_sel_i   (wbs_sel_i),
    .wbs_adr_i   (wbs_adr_i),
    .wbs_dat_i   (wbs_dat_i),
    .wbs_ack_o   (wbs_ack_o),
    .wbs_dat_o   (wbs_dat_o),
    .proj_io_out (proj_io_out),
    .proj_io_oeb (proj_io_oeb),
    .proj_la_out (proj_la_out),
    .proj_irq    (proj_irq),
    .proj_rst    (proj_rst),
    .io_out      (io_out),
    .io_oeb      (io_oeb),
    .la_data_out (la_data_out),
    .user_irq    (user_irq)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct packed {
    logic [7:0]  rst;
    logic [37:0] io;
    logic [37:0] oeb;
    logic [31:0] la;
    logic [2:0]  irq;
  } pad_t;

  int          compared   = 0;
  int          mismatched = 0;
  pad_t        pad_q[$];
  string       pad_nm[$];
  logic [31:0] rd_q[$];
  string       rd_nm[$];
  logic        watch3 = 1'b0;
  logic        saw3   = 1'b0;
  pad_t        mon_e;
  pad_t        mon_a;
  string       mon_n;
  logic [31:0] mon_d;

  // Project k drives io_out=k, io_oeb=k+16, la=0xA0+k, irq=k[2:0]
  initial begin
    for (int k = 0; k < NP; k++) begin
      proj_io_out[k*IO_W +: IO_W] = 38'(k);
      proj_io_oeb[k*IO_W +: IO_W] = 38'(k + 16);
      proj_la_out[k*LA_W +: LA_W] = 32'hA0 + 32'(k);
      proj_irq[k*3 +: 3]          = 3'(k);
    end
  end

  // Monitor: compares queued pad expectations and read acknowledges
  always @(negedge wb_clk_i) begin
    if (watch3 && !proj_rst[3]) saw3 = 1'b1;
    while (pad_q.size() > 0) begin
      mon_e = pad_q.pop_front();
      mon_n = pad_nm.pop_front();
      mon_a = {proj_rst, io_out, io_oeb, la_data_out, user_irq};
      compared++;
      if (mon_a !== mon_e) begin
        mismatched++;
        $display("FAIL %s: got rst=%h io=%h oeb=%h la=%h irq=%h, expected rst=%h io=%h oeb=%h la=%h irq=%h",
                 mon_n, mon_a.rst, mon_a.io, mon_a.oeb, mon_a.la, mon_a.irq,
                 mon_e.rst, mon_e.io, mon_e.oeb, mon_e.la, mon_e.irq);
      end
    end
    if (wbs_ack_o && !wbs_we_i) begin
      compared++;
      if (rd_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_read_ack: got ack with data %h, expected no ack", wbs_dat_o);
      end else begin
        mon_d = rd_q.pop_front();
        mon_n = rd_nm.pop_front();
        if (wbs_dat_o !== mon_d) begin
          mismatched++;
          $display("FAIL %s: got %h, expected %h", mon_n, wbs_dat_o, mon_d);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge wb_clk_i);
    #1;
  endtask

  task automatic exp_iso(input string nm);
    pad_t e;
    e.rst = 8'hFF; e.io = '0; e.oeb = '1; e.la = '0; e.irq = '0;
    pad_q.push_back(e);
    pad_nm.push_back(nm);
  endtask

  task automatic exp_proj(input string nm, input int k, input logic [7:0] rst_v);
    pad_t e;
    e.rst = rst_v; e.io = 38'(k); e.oeb = 38'(k + 16);
    e.la = 32'hA0 + 32'(k); e.irq = 3'(k);
    pad_q.push_back(e);
    pad_nm.push_back(nm);
  endtask

  // One Wishbone access; the acknowledge must arrive one cycle after strobe
  task automatic wb_cycle(input logic [31:0] adr, input logic we,
                          input logic [3:0] sel, input logic [31:0] dat);
    wbs_adr_i = adr; wbs_we_i = we; wbs_sel_i = sel; wbs_dat_i = dat;
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    compared++;
    if (!wbs_ack_o) begin
      mismatched++;
      $display("FAIL ack_latency adr=%h: got ack=0 one cycle after strobe, expected 1", adr);
      for (int i = 0; i < 8 && !wbs_ack_o; i++) @(negedge wb_clk_i);
    end
    @(posedge wb_clk_i);
    #1;
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel = 4'hF);
    wb_cycle(adr, 1'b1, sel, dat);
  endtask

  task automatic wb_read(input string nm, input logic [31:0] adr, input logic [31:0] exp);
    rd_q.push_back(exp);
    rd_nm.push_back(nm);
    wb_cycle(adr, 1'b0, 4'hF, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_ack;
    // Reset and default bring-up
    repeat (3) @(posedge wb_clk_i);
    #1;
    exp_iso("reset_pads");
    compared++;
    if (wbs_ack_o !== 1'b0 || wbs_dat_o !== 32'h0) begin
      mismatched++;
      $display("FAIL reset_wb: got ack=%b dat=%h, expected ack=0 dat=0", wbs_ack_o, wbs_dat_o);
    end
    wb_rst_i = 1'b0;
    tick(1);  exp_iso("release_plus1");
    tick(11); exp_iso("before_default_active");
    tick(1);  exp_proj("default_live", 0, 8'hFE);
    wb_read("status_idle", BASE + 32'h8, 32'h0000_0800);
    wb_read("sel_default", BASE + 32'h0, 32'h0);

    // Switch to project 5
    wb_write(BASE + 32'h0, 32'd5);
    exp_proj("sel5_old_still_live", 0, 8'hFE);
    tick(1);  exp_iso("sel5_isolate_first");
    tick(11); exp_iso("sel5_isolate_last");
    tick(1);  exp_proj("sel5_live", 5, 8'hDF);
    wb_read("sel_read5", BASE + 32'h0, 32'd5);

    // Out-of-range select, then a valid one
    wb_write(BASE + 32'h0, 32'd9);
    wb_read("status_err", BASE + 32'h8, 32'h0000_0802);
    wb_read("sel_unchanged", BASE + 32'h0, 32'd5);
    wb_write(BASE + 32'h0, 32'd2);
    wb_read("status_busy_errclr", BASE + 32'h8, 32'h0000_0801);
    tick(10); exp_iso("sel2_isolate_last");
    tick(1);  exp_proj("sel2_live", 2, 8'hFB);

    // Requests during ISOLATE and RESET
    watch3 = 1'b1;
    wb_write(BASE + 32'h0, 32'd1);
    wb_write(BASE + 32'h0, 32'd3);
    tick(3);
    wb_write(BASE + 32'h0, 32'd6);
    tick(6);  exp_proj("first_seq_target1", 1, 8'hFD);
    tick(1);  exp_iso("reseq_isolate");
    tick(11); exp_iso("reseq_isolate_last");
    tick(1);  exp_proj("final_target6", 6, 8'hBF);
    wb_read("sel_read6", BASE + 32'h0, 32'd6);
    watch3 = 1'b0;
    compared++;
    if (saw3 !== 1'b0) begin
      mismatched++;
      $display("FAIL proj3_never_active: got proj_rst[3] low at some point, expected always high");
    end

    // Disable / re-enable
    wb_write(BASE + 32'h4, 32'd0);
    exp_iso("ctrl_disabled");
    wb_read("status_disabled", BASE + 32'h8, 32'h0000_0800);
    wb_read("ctrl_read0", BASE + 32'h4, 32'h0);
    wb_write(BASE + 32'h4, 32'd1);
    exp_proj("reenabled_no_guard", 6, 8'hBF);

    // Byte lane 0 not selected and write to 0xC are ignored
    wb_write(BASE + 32'h0, 32'd3, 4'b1110);
    wb_read("sel_lane0_off", BASE + 32'h0, 32'd6);
    wb_read("status_lane0_off", BASE + 32'h8, 32'h0000_0800);
    wb_write(BASE + 32'hC, 32'hFFFF_FFFF);
    wb_read("reg_c_zero", BASE + 32'hC, 32'h0);

    // Reset in the middle of a switch to 4
    wb_write(BASE + 32'h0, 32'd4);
    tick(5);
    wb_rst_i = 1'b1;
    tick(1);
    exp_iso("midseq_reset_pads");
    wb_rst_i = 1'b0;
    wb_read("sel_after_reset", BASE + 32'h0, 32'd0);
    wb_read("status_after_reset", BASE + 32'h8, 32'h0000_0801);
    tick(8);  exp_iso("restart_isolate_last");
    tick(1);  exp_proj("restart_default_live", 0, 8'hFE);
    tick(14); exp_proj("no_stale_pending", 0, 8'hFE);

    // Address outside the register block gets no acknowledge
    wbs_adr_i = BASE + 32'h10; wbs_we_i = 1'b0; wbs_sel_i = 4'hF;
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
    n_ack = 0;
    repeat (4) begin
      @(negedge wb_clk_i);
      if (wbs_ack_o) n_ack++;
    end
    @(posedge wb_clk_i);
    #1;
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
    compared++;
    if (n_ack != 0) begin
      mismatched++;
      $display("FAIL no_ack_out_of_range: got %0d acks, expected 0", n_ack);
    end

    tick(3);
    compared++;
    if (pad_q.size() != 0 || rd_q.size() != 0) begin
      mismatched++;
      $display("FAIL queues_drained: got pad=%0d rd=%0d pending, expected 0 0", pad_q.size(), rd_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
